// File: rtl/regfile_write_arbiter.sv
// Shares the single register-file write port between NUM_REQ writeback sources.
// Each source owns a one-entry buffer; a round-robin pick honours per-register write order.
`timescale 1ns/1ps
module regfile_write_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int REG_BITS  = 5,
  parameter int DATA_BITS = 32
) (
  input  logic                           clock,
  input  logic                           ctrl_reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*REG_BITS-1:0]    req_reg,
  input  logic [NUM_REQ*DATA_BITS-1:0]   req_data,
  output logic                           ctrl_writeEnable,
  output logic [REG_BITS-1:0]            ctrl_writeReg,
  output logic [DATA_BITS-1:0]           data_writeReg,
  output logic [(1<<REG_BITS)-1:0]       pending_mask
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]   buf_v;
  logic [REG_BITS-1:0]  buf_reg  [NUM_REQ];
  logic [DATA_BITS-1:0] buf_data [NUM_REQ];
  // older[i][j] set means buffer j was loaded before buffer i
  logic [NUM_REQ-1:0]   older    [NUM_REQ];
  logic [PTR_W-1:0]     rr_ptr;

  logic [NUM_REQ-1:0]   eligible;
  logic [NUM_REQ-1:0]   grant;
  logic [NUM_REQ-1:0]   load;
  logic                 any_grant;
  logic [PTR_W-1:0]     win_idx;
  logic [PTR_W-1:0]     rr_next;

  always_comb begin
    eligible = buf_v;
    for (int i = 0; i < NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (j != i && buf_v[j] && older[i][j] && buf_reg[j] == buf_reg[i])
          eligible[i] = 1'b0;
      end
    end
  end

  // Two passes give the wrap-around search starting at rr_ptr
  always_comb begin
    grant     = '0;
    any_grant = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_grant && eligible[i] && i >= int'(rr_ptr)) begin
        grant[i]  = 1'b1;
        any_grant = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!any_grant && eligible[i] && i < int'(rr_ptr)) begin
        grant[i]  = 1'b1;
        any_grant = 1'b1;
        win_idx   = PTR_W'(i);
      end
    end
  end

  assign rr_next   = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
  assign req_ready = ~buf_v | grant;

  // r0 is hardwired zero: such requests are accepted but never buffered
  always_comb begin
    load = '0;
    for (int i = 0; i < NUM_REQ; i++)
      load[i] = req_valid[i] & req_ready[i] & (req_reg[i*REG_BITS +: REG_BITS] != '0);
  end

  always_ff @(posedge clock or posedge ctrl_reset) begin
    if (ctrl_reset) begin
      buf_v            <= '0;
      rr_ptr           <= '0;
      ctrl_writeEnable <= 1'b0;
      ctrl_writeReg    <= '0;
      data_writeReg    <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        buf_reg[i]  <= '0;
        buf_data[i] <= '0;
        older[i]    <= '0;
      end
    end else begin
      // port stage
      ctrl_writeEnable <= any_grant;
      if (any_grant) begin
        rr_ptr        <= rr_next;
        ctrl_writeReg <= buf_reg[win_idx];
        data_writeReg <= buf_data[win_idx];
      end
      // buffer stage
      for (int i = 0; i < NUM_REQ; i++) begin
        if (load[i]) begin
          buf_v[i]    <= 1'b1;
          buf_reg[i]  <= req_reg[i*REG_BITS +: REG_BITS];
          buf_data[i] <= req_data[i*DATA_BITS +: DATA_BITS];
        end else if (grant[i]) begin
          buf_v[i] <= 1'b0;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        for (int j = 0; j < NUM_REQ; j++) begin
          if (load[i]) begin
            if (j == i)
              older[i][j] <= 1'b0;
            else if (load[j])
              older[i][j] <= (j < i) ? 1'b1 : 1'b0;
            else
              older[i][j] <= buf_v[j] & ~grant[j];
          end else if (load[j]) begin
            older[i][j] <= 1'b0;
          end
        end
      end
    end
  end

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (buf_v[i]) pending_mask[buf_reg[i]] = 1'b1;
    if (ctrl_writeEnable) pending_mask[ctrl_writeReg] = 1'b1;
    pending_mask[0] = 1'b0;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed cases plus random traffic checked
// against an age-sequence reference model through a write scoreboard.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

  localparam int N  = 3;
  localparam int RB = 5;
  localparam int DB = 32;

  logic              clk = 1'b0;
  logic              ctrl_reset = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*RB-1:0]   req_reg = '0;
  logic [N*DB-1:0]   req_data = '0;
  logic              ctrl_writeEnable;
  logic [RB-1:0]     ctrl_writeReg;
  logic [DB-1:0]     data_writeReg;
  logic [31:0]       pending_mask;

  regfile_write_arbiter #(.NUM_REQ(N), .REG_BITS(RB), .DATA_BITS(DB)) dut (
    .clock(clk), .ctrl_reset(ctrl_reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_reg(req_reg), .req_data(req_data), .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg), .pending_mask(pending_mask)
  );

  always #5 clk = ~clk;

  typedef struct { int r; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  wr_t mon_e;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: buffers tagged with a global load sequence number
  bit          m_v[N];
  int          m_reg[N];
  logic [31:0] m_data[N];
  int          m_seq[N];
  int          seq_ctr = 0;
  int          m_rr = 0;
  bit          m_pwe = 0;
  int          m_preg = 0;
  int          win = -1;
  bit          m_ready[N];
  bit          last_ready[N];

  bit          drv_v[N];
  int          drv_r[N];
  logic [31:0] drv_d[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_elig(input int i);
    for (int j = 0; j < N; j++)
      if (j != i && m_v[j] && m_reg[j] == m_reg[i] && m_seq[j] < m_seq[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [31:0] model_pm();
    logic [31:0] pm;
    pm = '0;
    for (int i = 0; i < N; i++) if (m_v[i]) pm[m_reg[i]] = 1'b1;
    if (m_pwe) pm[m_preg] = 1'b1;
    pm[0] = 1'b0;
    return pm;
  endfunction

  task automatic model_eval();
    int i;
    win = -1;
    for (int k = 0; k < N; k++) begin
      i = (m_rr + k) % N;
      if (win < 0 && m_v[i] && is_elig(i)) win = i;
    end
    for (int q = 0; q < N; q++) m_ready[q] = !m_v[q] || (win == q);
  endtask

  task automatic model_update();
    m_pwe = (win >= 0);
    if (win >= 0) begin
      m_preg = m_reg[win];
      exp_q.push_back('{m_reg[win], m_data[win]});
      m_rr = (win + 1) % N;
      m_v[win] = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      if (drv_v[i] && m_ready[i] && drv_r[i] != 0) begin
        m_v[i] = 1'b1; m_reg[i] = drv_r[i]; m_data[i] = drv_d[i];
        m_seq[i] = seq_ctr; seq_ctr++;
      end
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) m_v[i] = 1'b0;
    m_pwe = 1'b0; m_rr = 0; m_preg = 0;
    exp_q.delete();
  endtask

  task automatic apply();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = drv_v[i];
      req_reg[i*RB +: RB]    = RB'(drv_r[i]);
      req_data[i*DB +: DB]   = drv_d[i];
    end
  endtask

  // one clock cycle: called just after a falling edge, returns at the next one
  task automatic step();
    apply();
    #1;
    model_eval();
    for (int i = 0; i < N; i++) chk($sformatf("ready%0d", i), 64'(req_ready[i]), 64'(m_ready[i]));
    chk("we", 64'(ctrl_writeEnable), 64'(m_pwe));
    chk("pending", 64'(pending_mask), 64'(model_pm()));
    for (int i = 0; i < N; i++) last_ready[i] = m_ready[i];
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // drive a source unless it is stalled, in which case its request is held
  task automatic set_src(input int i, input bit v, input int r, input logic [31:0] d);
    if (drv_v[i] && !last_ready[i]) return;
    drv_v[i] = v; drv_r[i] = r; drv_d[i] = d;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < N; i++) set_src(i, 1'b0, 0, 32'h0);
      step();
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!ctrl_reset && ctrl_writeEnable) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_write: got reg %0d data %0h, expected no write", ctrl_writeReg, data_writeReg);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_reg", 64'(ctrl_writeReg), 64'(mon_e.r));
        chk("wr_data", 64'(data_writeReg), 64'(mon_e.d));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      drv_v[i] = 0; drv_r[i] = 0; drv_d[i] = '0; m_v[i] = 0; last_ready[i] = 1;
    end
    apply();
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    chk("rst_we", 64'(ctrl_writeEnable), 64'd0);
    chk("rst_wreg", 64'(ctrl_writeReg), 64'd0);
    chk("rst_wdata", 64'(data_writeReg), 64'd0);
    chk("rst_pending", 64'(pending_mask), 64'd0);
    ctrl_reset = 1'b0;
    #1;
    chk("rst_ready", 64'(req_ready), 64'((1 << N) - 1));
    @(negedge clk);

    // single source write and its latency
    set_src(0, 1'b1, 5, 32'hDEADBEEF);
    step();
    idle(1);
    chk("t1_we", 64'(ctrl_writeEnable), 64'd1);
    chk("t1_reg", 64'(ctrl_writeReg), 64'd5);
    chk("t1_data", 64'(data_writeReg), 64'hDEADBEEF);
    chk("t1_pend5", 64'(pending_mask[5]), 64'd1);
    idle(2);

    // two sources streaming to distinct registers
    for (int k = 0; k < 10; k++) begin
      set_src(0, 1'b1, 3, $urandom);
      set_src(1, 1'b1, 7, $urandom);
      step();
    end
    idle(4);

    // same register, src1 first then src0
    set_src(1, 1'b1, 9, 32'd1);
    step();
    set_src(1, 1'b0, 0, 32'd0);
    set_src(0, 1'b1, 9, 32'd2);
    step();
    idle(4);

    // simultaneous loads to the same register
    set_src(0, 1'b1, 4, 32'hA);
    set_src(1, 1'b1, 4, 32'hB);
    step();
    idle(5);

    // writes to r0 are swallowed
    set_src(0, 1'b1, 0, 32'hFFFF);
    step();
    idle(3);

    // reset while every buffer is occupied and the port is busy
    set_src(0, 1'b1, 10, 32'h10);
    set_src(1, 1'b1, 11, 32'h11);
    set_src(2, 1'b1, 12, 32'h12);
    step();
    for (int i = 0; i < N; i++) set_src(i, 1'b1, 20 + i, 32'h20 + i);
    step();
    #1;
    ctrl_reset = 1'b1;
    for (int i = 0; i < N; i++) begin drv_v[i] = 0; drv_r[i] = 0; drv_d[i] = '0; last_ready[i] = 1; end
    apply();
    model_clear();
    #1;
    chk("mid_rst_we", 64'(ctrl_writeEnable), 64'd0);
    chk("mid_rst_pending", 64'(pending_mask), 64'd0);
    @(posedge clk);
    @(negedge clk);
    ctrl_reset = 1'b0;
    idle(4);

    // random traffic with register collisions and r0 requests
    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < N; i++)
        set_src(i, ($urandom_range(0, 99) < 65), $urandom_range(0, 6), $urandom);
      step();
    end

    for (int k = 0; k < 20 && (exp_q.size() != 0 || m_v[0] || m_v[1] || m_v[2] || m_pwe); k++)
      idle(1);
    chk("drain", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
